// File: rtl/plugboard_pkg.sv
// rtl/plugboard_pkg.sv - shared types for the Enigma plugboard block
//   Provides the config opcode, error code and config FSM state encodings
//   used by plugboard_pairs and pb_lookup_stage.
package plugboard_pkg;

    localparam int CFG_OP_W = 2;
    localparam int CFG_ERR_W = 3;

    typedef enum logic [CFG_OP_W-1:0] {
        OP_ADD   = 2'd0,
        OP_DEL   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } cfg_op_e;

    typedef enum logic [CFG_ERR_W-1:0] {
        ERR_OK     = 3'd0,
        ERR_RANGE  = 3'd1,
        ERR_SELF   = 3'd2,
        ERR_BUSY   = 3'd3,
        ERR_FULL   = 3'd4,
        ERR_NOPAIR = 3'd5,
        ERR_OP     = 3'd6,
        ERR_LOCKED = 3'd7
    } pb_err_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_WRITE     = 3'd2,
        S_CLEAR_RUN = 3'd3,
        S_DONE      = 3'd4
    } pb_state_e;

endpackage

// File: rtl/pb_lookup_stage.sv
// rtl/pb_lookup_stage.sv - one registered plugboard lookup channel
//   clk, rst_n          : clock, async active-low reset
//   stall               : high while the LUT is being cleared; blocks acceptance
//   lut_flat            : LUT read bus, entry i at [i*CHAR_W +: CHAR_W]
//   in_valid/in_ready   : input letter handshake
//   in_char             : letter to translate
//   out_valid/out_char  : registered result, one cycle after acceptance
module pb_lookup_stage
    import plugboard_pkg::*;
#(
    parameter int ALPHA_N = 26,
    parameter int CHAR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic [ALPHA_N*CHAR_W-1:0] lut_flat,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHAR_W-1:0]         in_char,
    output logic                      out_valid,
    output logic [CHAR_W-1:0]         out_char
);

    logic              out_valid_q, out_valid_d;
    logic [CHAR_W-1:0] out_char_q, out_char_d;
    logic [CHAR_W-1:0] lut_val;
    logic              accept;

    // The consumer always takes the result the cycle after it appears, so
    // the output register never blocks a new letter; only a clear does.
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Letters outside the alphabet are passed through unchanged.
    always_comb begin
        lut_val = in_char;
        for (int i = 0; i < ALPHA_N; i++) begin
            if (in_char == CHAR_W'(i)) begin
                lut_val = lut_flat[i*CHAR_W +: CHAR_W];
            end
        end
    end

    always_comb begin
        out_valid_d = accept;
        out_char_d  = out_char_q;
        if (accept) begin
            out_char_d = lut_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;

endmodule

// File: rtl/plugboard_pairs.sv
// rtl/plugboard_pairs.sv - run-time programmable Enigma plugboard (involutive LUT)
//   Optional macro PB_CFG_LOCK_EN adds input cfg_lock that refuses all config ops.
//   clk, rst_n                : clock, async active-low reset
//   cfg_valid/cfg_ready       : config request handshake (ready only when idle)
//   cfg_op, cfg_a, cfg_b      : ADD/DEL/CLEAR/reserved and the two letters
//   cfg_lock                  : (PB_CFG_LOCK_EN only) refuse config requests
//   cfg_done, cfg_err         : completion pulse and its error code
//   pair_cnt                  : number of cables installed
//   fw_* / rev_*              : forward and reverse lookup channels
module plugboard_pairs
    import plugboard_pkg::*;
#(
    parameter int ALPHA_N   = 26,
    parameter int CHAR_W    = 5,
    parameter int MAX_PAIRS = 13
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_valid,
`ifdef PB_CFG_LOCK_EN
    input  logic                             cfg_lock,
`endif
    output logic                             cfg_ready,
    input  logic [CFG_OP_W-1:0]              cfg_op,
    input  logic [CHAR_W-1:0]                cfg_a,
    input  logic [CHAR_W-1:0]                cfg_b,
    output logic                             cfg_done,
    output logic [CFG_ERR_W-1:0]             cfg_err,
    output logic [$clog2(MAX_PAIRS+1)-1:0]   pair_cnt,
    input  logic                             fw_in_valid,
    output logic                             fw_in_ready,
    input  logic [CHAR_W-1:0]                fw_in_char,
    output logic                             fw_out_valid,
    output logic [CHAR_W-1:0]                fw_out_char,
    input  logic                             rev_in_valid,
    output logic                             rev_in_ready,
    input  logic [CHAR_W-1:0]                rev_in_char,
    output logic                             rev_out_valid,
    output logic [CHAR_W-1:0]                rev_out_char
);

    localparam int PC_W = $clog2(MAX_PAIRS+1);

    pb_state_e         state_q, state_d;
    cfg_op_e           op_q, op_d;
    pb_err_e           err_q, err_d;
    logic [CHAR_W-1:0] a_q, a_d;
    logic [CHAR_W-1:0] b_q, b_d;
    logic [CHAR_W-1:0] idx_q, idx_d;
    logic [PC_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [CHAR_W-1:0] lut_q [ALPHA_N];
    logic [CHAR_W-1:0] lut_d [ALPHA_N];

    logic [ALPHA_N*CHAR_W-1:0] lut_flat;
    logic [CHAR_W-1:0]         lut_a, lut_b;
    logic                      a_ok, b_ok;
    logic                      lock_req;
    logic                      clear_stall;
    pb_err_e                   chk_err;

`ifdef PB_CFG_LOCK_EN
    assign lock_req = cfg_lock;
`else
    assign lock_req = 1'b0;
`endif

    function automatic logic [CHAR_W-1:0] lut_rd(input logic [ALPHA_N*CHAR_W-1:0] flat,
                                                 input logic [CHAR_W-1:0]         idx);
        logic [CHAR_W-1:0] r;
        r = idx;
        for (int i = 0; i < ALPHA_N; i++) begin
            if (idx == CHAR_W'(i)) begin
                r = flat[i*CHAR_W +: CHAR_W];
            end
        end
        return r;
    endfunction

    always_comb begin
        lut_flat = '0;
        for (int i = 0; i < ALPHA_N; i++) begin
            lut_flat[i*CHAR_W +: CHAR_W] = lut_q[i];
        end
    end

    assign a_ok  = int'(a_q) < ALPHA_N;
    assign b_ok  = int'(b_q) < ALPHA_N;
    assign lut_a = lut_rd(lut_flat, a_q);
    assign lut_b = lut_rd(lut_flat, b_q);

    // Wiring legality of the latched request, highest priority first.
    always_comb begin
        chk_err = ERR_OK;
        if (!a_ok || !b_ok) begin
            chk_err = ERR_RANGE;
        end else if (a_q == b_q) begin
            chk_err = ERR_SELF;
        end else if (op_q == OP_ADD) begin
            if ((lut_a != a_q) || (lut_b != b_q)) begin
                chk_err = ERR_BUSY;
            end else if (pair_cnt_q == PC_W'(MAX_PAIRS)) begin
                chk_err = ERR_FULL;
            end
        end else if (lut_a != b_q) begin
            chk_err = ERR_NOPAIR;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        err_d      = err_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        pair_cnt_d = pair_cnt_q;
        lut_d      = lut_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    op_d  = cfg_op_e'(cfg_op);
                    a_d   = cfg_a;
                    b_d   = cfg_b;
                    idx_d = '0;
                    err_d = ERR_OK;
                    if (lock_req) begin
                        err_d   = ERR_LOCKED;
                        state_d = S_DONE;
                    end else begin
                        case (cfg_op_e'(cfg_op))
                            OP_ADD, OP_DEL: state_d = S_CHECK;
                            OP_CLEAR:       state_d = S_CLEAR_RUN;
                            default: begin
                                err_d   = ERR_OP;
                                state_d = S_DONE;
                            end
                        endcase
                    end
                end
            end

            S_CHECK: begin
                err_d   = chk_err;
                state_d = (chk_err == ERR_OK) ? S_WRITE : S_DONE;
            end

            // Both halves of the cable change on the same edge so the LUT is
            // never observed half-wired.
            S_WRITE: begin
                for (int i = 0; i < ALPHA_N; i++) begin
                    if (a_q == CHAR_W'(i)) begin
                        lut_d[i] = (op_q == OP_ADD) ? b_q : a_q;
                    end
                    if (b_q == CHAR_W'(i)) begin
                        lut_d[i] = (op_q == OP_ADD) ? a_q : b_q;
                    end
                end
                pair_cnt_d = (op_q == OP_ADD) ? pair_cnt_q + PC_W'(1)
                                              : pair_cnt_q - PC_W'(1);
                state_d    = S_DONE;
            end

            S_CLEAR_RUN: begin
                for (int i = 0; i < ALPHA_N; i++) begin
                    if (idx_q == CHAR_W'(i)) begin
                        lut_d[i] = CHAR_W'(i);
                    end
                end
                if (idx_q == CHAR_W'(ALPHA_N-1)) begin
                    pair_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    idx_d = idx_q + CHAR_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            err_q      <= ERR_OK;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            pair_cnt_q <= '0;
            for (int i = 0; i < ALPHA_N; i++) begin
                lut_q[i] <= CHAR_W'(i);
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            err_q      <= err_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            pair_cnt_q <= pair_cnt_d;
            lut_q      <= lut_d;
        end
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign cfg_done    = (state_q == S_DONE);
    assign cfg_err     = cfg_done ? err_q : ERR_OK;
    assign pair_cnt    = pair_cnt_q;
    assign clear_stall = (state_q == S_CLEAR_RUN);

    pb_lookup_stage #(
        .ALPHA_N (ALPHA_N),
        .CHAR_W  (CHAR_W)
    ) u_fw (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (clear_stall),
        .lut_flat  (lut_flat),
        .in_valid  (fw_in_valid),
        .in_ready  (fw_in_ready),
        .in_char   (fw_in_char),
        .out_valid (fw_out_valid),
        .out_char  (fw_out_char)
    );

    // The table is its own inverse, so the reverse channel reads the same LUT.
    pb_lookup_stage #(
        .ALPHA_N (ALPHA_N),
        .CHAR_W  (CHAR_W)
    ) u_rev (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (clear_stall),
        .lut_flat  (lut_flat),
        .in_valid  (rev_in_valid),
        .in_ready  (rev_in_ready),
        .in_char   (rev_in_char),
        .out_valid (rev_out_valid),
        .out_char  (rev_out_char)
    );

    // Involution and cable count must hold except while a clear is sweeping.
    logic inv_ok;
    always_comb begin
        int cnt;
        cnt    = 0;
        inv_ok = 1'b1;
        for (int i = 0; i < ALPHA_N; i++) begin
            if (int'(lut_q[i]) >= ALPHA_N) begin
                inv_ok = 1'b0;
            end else if (lut_rd(lut_flat, lut_q[i]) != CHAR_W'(i)) begin
                inv_ok = 1'b0;
            end
            if (int'(lut_q[i]) > i) begin
                cnt = cnt + 1;
            end
        end
        if (cnt != int'(pair_cnt_q)) begin
            inv_ok = 1'b0;
        end
    end

    inv_assert: assert property (@(posedge clk) disable iff (!rst_n)
                                 (state_q == S_CLEAR_RUN) || inv_ok);

endmodule

// File: tb/tb_plugboard_pairs.sv
// tb/tb_plugboard_pairs.sv - directed self-checking bench for plugboard_pairs
module tb_plugboard_pairs;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    bit         sel   = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_op = 2'd0;
    logic [4:0] cfg_a = 5'd0;
    logic [4:0] cfg_b = 5'd0;
`ifdef PB_CFG_LOCK_EN
    logic       cfg_lock = 1'b0;
`endif
    logic       fw_in_valid = 1'b0;
    logic       rev_in_valid = 1'b0;
    logic [4:0] fw_in_char = 5'd0;
    logic [4:0] rev_in_char = 5'd0;

    int errors = 0;
    int checks = 0;

    logic       cfg_valid_1, cfg_valid_2, fw_in_valid_1, fw_in_valid_2;
    logic       rev_in_valid_1, rev_in_valid_2;
    logic       cfg_ready_1, cfg_ready_2, cfg_done_1, cfg_done_2;
    logic [2:0] cfg_err_1, cfg_err_2;
    logic [3:0] pair_cnt_1, pair_cnt_2;
    logic       fw_in_ready_1, fw_in_ready_2, fw_out_valid_1, fw_out_valid_2;
    logic [4:0] fw_out_char_1, fw_out_char_2;
    logic       rev_in_ready_1, rev_in_ready_2, rev_out_valid_1, rev_out_valid_2;
    logic [4:0] rev_out_char_1, rev_out_char_2;

    logic       cfg_ready_m, cfg_done_m, fw_in_ready_m, rev_in_ready_m;
    logic       fw_out_valid_m, rev_out_valid_m;
    logic [2:0] cfg_err_m;
    logic [3:0] pair_cnt_m;
    logic [4:0] fw_out_char_m, rev_out_char_m;

    assign cfg_valid_1    = cfg_valid & ~sel;
    assign cfg_valid_2    = cfg_valid & sel;
    assign fw_in_valid_1  = fw_in_valid & ~sel;
    assign fw_in_valid_2  = fw_in_valid & sel;
    assign rev_in_valid_1 = rev_in_valid & ~sel;
    assign rev_in_valid_2 = rev_in_valid & sel;

    assign cfg_ready_m     = sel ? cfg_ready_2     : cfg_ready_1;
    assign cfg_done_m      = sel ? cfg_done_2      : cfg_done_1;
    assign cfg_err_m       = sel ? cfg_err_2       : cfg_err_1;
    assign pair_cnt_m      = sel ? pair_cnt_2      : pair_cnt_1;
    assign fw_in_ready_m   = sel ? fw_in_ready_2   : fw_in_ready_1;
    assign fw_out_valid_m  = sel ? fw_out_valid_2  : fw_out_valid_1;
    assign fw_out_char_m   = sel ? fw_out_char_2   : fw_out_char_1;
    assign rev_in_ready_m  = sel ? rev_in_ready_2  : rev_in_ready_1;
    assign rev_out_valid_m = sel ? rev_out_valid_2 : rev_out_valid_1;
    assign rev_out_char_m  = sel ? rev_out_char_2  : rev_out_char_1;

    plugboard_pairs #(.ALPHA_N(26), .CHAR_W(5), .MAX_PAIRS(13)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid_1),
`ifdef PB_CFG_LOCK_EN
        .cfg_lock(cfg_lock),
`endif
        .cfg_ready(cfg_ready_1), .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_done(cfg_done_1), .cfg_err(cfg_err_1), .pair_cnt(pair_cnt_1),
        .fw_in_valid(fw_in_valid_1), .fw_in_ready(fw_in_ready_1), .fw_in_char(fw_in_char),
        .fw_out_valid(fw_out_valid_1), .fw_out_char(fw_out_char_1),
        .rev_in_valid(rev_in_valid_1), .rev_in_ready(rev_in_ready_1), .rev_in_char(rev_in_char),
        .rev_out_valid(rev_out_valid_1), .rev_out_char(rev_out_char_1)
    );

    plugboard_pairs #(.ALPHA_N(28), .CHAR_W(5), .MAX_PAIRS(13)) dut28 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid_2),
`ifdef PB_CFG_LOCK_EN
        .cfg_lock(cfg_lock),
`endif
        .cfg_ready(cfg_ready_2), .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .cfg_done(cfg_done_2), .cfg_err(cfg_err_2), .pair_cnt(pair_cnt_2),
        .fw_in_valid(fw_in_valid_2), .fw_in_ready(fw_in_ready_2), .fw_in_char(fw_in_char),
        .fw_out_valid(fw_out_valid_2), .fw_out_char(fw_out_char_2),
        .rev_in_valid(rev_in_valid_2), .rev_in_ready(rev_in_ready_2), .rev_in_char(rev_in_char),
        .rev_out_valid(rev_out_valid_2), .rev_out_char(rev_out_char_2)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        cfg_valid = 1'b0; fw_in_valid = 1'b0; rev_in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one config request; lat = cycles from accept to done pulse (60 = timeout).
    task automatic do_cfg(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                          output logic [2:0] err, output int lat);
        int n;
        n = 0;
        while (!cfg_ready_m && n < 20) begin
            tick();
            n++;
        end
        cfg_valid = 1'b1; cfg_op = op; cfg_a = a; cfg_b = b;
        tick();
        cfg_valid = 1'b0;
        lat = 1;
        while (!cfg_done_m && lat < 60) begin
            tick();
            lat++;
        end
        err = cfg_err_m;
    endtask

    task automatic look(input logic [4:0] fc, input logic [4:0] rc,
                        output logic [5:0] fo, output logic [5:0] ro);
        fw_in_valid = 1'b1; fw_in_char = fc;
        rev_in_valid = 1'b1; rev_in_char = rc;
        tick();
        fw_in_valid = 1'b0; rev_in_valid = 1'b0;
        fo = {fw_out_valid_m, fw_out_char_m};
        ro = {rev_out_valid_m, rev_out_char_m};
    endtask

    task automatic test_reset();
        logic [5:0] fo, ro;
        apply_reset();
        checks++;
        if ({cfg_ready_m, cfg_done_m, cfg_err_m, pair_cnt_m} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_cfg: got rdy=%0b done=%0b err=%0d cnt=%0d want 1 0 0 0",
                     cfg_ready_m, cfg_done_m, cfg_err_m, pair_cnt_m);
        end
        checks++;
        if ({fw_out_valid_m, fw_out_char_m, rev_out_valid_m, rev_out_char_m} !== 12'h000) begin
            errors++;
            $display("FAIL reset_out: got fw=%0b/%0d rev=%0b/%0d want 0/0 0/0",
                     fw_out_valid_m, fw_out_char_m, rev_out_valid_m, rev_out_char_m);
        end
        look(5'd0, 5'd25, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd0} || ro !== {1'b1, 5'd25}) begin
            errors++;
            $display("FAIL reset_lookup: got fw=%h rev=%h want 20 39", fo, ro);
        end
    endtask

    task automatic test_add();
        logic [2:0] err;
        int lat;
        logic [5:0] fo, ro;
        do_cfg(2'd0, 5'd0, 5'd4, err, lat);
        checks++;
        if (lat !== 3 || err !== 3'd0 || pair_cnt_m !== 4'd1) begin
            errors++;
            $display("FAIL add_0_4: got lat=%0d err=%0d cnt=%0d want 3 0 1", lat, err, pair_cnt_m);
        end
        look(5'd0, 5'd4, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd4} || ro !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL add_lookup_a: got fw=%h rev=%h want 24 20", fo, ro);
        end
        look(5'd4, 5'd9, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd0} || ro !== {1'b1, 5'd9}) begin
            errors++;
            $display("FAIL add_lookup_b: got fw=%h rev=%h want 20 29", fo, ro);
        end
    endtask

    task automatic test_errors();
        int t_op  [5] = '{0, 0, 0, 1, 3};
        int t_a   [5] = '{4, 3, 26, 0, 1};
        int t_b   [5] = '{9, 3, 1, 9, 2};
        int t_err [5] = '{3, 2, 1, 5, 6};
        int t_lat [5] = '{2, 2, 2, 2, 1};
        logic [2:0] err;
        int lat;
        logic [5:0] fo, ro;
        for (int i = 0; i < 5; i++) begin
            do_cfg(2'(t_op[i]), 5'(t_a[i]), 5'(t_b[i]), err, lat);
            checks++;
            if (err !== 3'(t_err[i]) || lat !== t_lat[i]) begin
                errors++;
                $display("FAIL err_case_%0d: got err=%0d lat=%0d want err=%0d lat=%0d",
                         i, err, lat, t_err[i], t_lat[i]);
            end
        end
        look(5'd0, 5'd30, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd4} || ro !== {1'b1, 5'd30} || pair_cnt_m !== 4'd1) begin
            errors++;
            $display("FAIL err_lut_unchanged: got fw=%h rev=%h cnt=%0d want 24 3e 1", fo, ro, pair_cnt_m);
        end
    endtask

    task automatic test_full();
        logic [2:0] err;
        int lat;
        logic [5:0] fo, ro;
        do_cfg(2'd1, 5'd0, 5'd4, err, lat);
        checks++;
        if (err !== 3'd0 || lat !== 3 || pair_cnt_m !== 4'd0) begin
            errors++;
            $display("FAIL del_0_4: got err=%0d lat=%0d cnt=%0d want 0 3 0", err, lat, pair_cnt_m);
        end
        for (int k = 0; k < 13; k++) begin
            do_cfg(2'd0, 5'(2*k), 5'(2*k+1), err, lat);
            checks++;
            if (err !== 3'd0 || lat !== 3) begin
                errors++;
                $display("FAIL fill_%0d: got err=%0d lat=%0d want 0 3", k, err, lat);
            end
        end
        checks++;
        if (pair_cnt_m !== 4'd13) begin
            errors++;
            $display("FAIL fill_count: got %0d want 13", pair_cnt_m);
        end
        look(5'd24, 5'd7, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd25} || ro !== {1'b1, 5'd6}) begin
            errors++;
            $display("FAIL fill_lookup: got fw=%h rev=%h want 39 26", fo, ro);
        end
        do_cfg(2'd1, 5'd0, 5'd1, err, lat);
        checks++;
        if (err !== 3'd0 || pair_cnt_m !== 4'd12) begin
            errors++;
            $display("FAIL full_del: got err=%0d cnt=%0d want 0 12", err, pair_cnt_m);
        end
        do_cfg(2'd0, 5'd0, 5'd1, err, lat);
        checks++;
        if (err !== 3'd0 || pair_cnt_m !== 4'd13) begin
            errors++;
            $display("FAIL full_readd: got err=%0d cnt=%0d want 0 13", err, pair_cnt_m);
        end
        sel = 1'b1;
        for (int k = 0; k < 13; k++) begin
            do_cfg(2'd0, 5'(2*k), 5'(2*k+1), err, lat);
        end
        do_cfg(2'd0, 5'd26, 5'd27, err, lat);
        checks++;
        if (err !== 3'd4 || lat !== 2 || pair_cnt_m !== 4'd13) begin
            errors++;
            $display("FAIL full_28: got err=%0d lat=%0d cnt=%0d want 4 2 13", err, lat, pair_cnt_m);
        end
        look(5'd26, 5'd27, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd26} || ro !== {1'b1, 5'd27}) begin
            errors++;
            $display("FAIL full_28_lookup: got fw=%h rev=%h want 3a 3b", fo, ro);
        end
        sel = 1'b0;
    endtask

    task automatic test_clear();
        int pa [5] = '{0, 1, 2, 3, 5};
        int pb [5] = '{4, 7, 11, 20, 25};
        logic [2:0] err;
        int lat, stalls, n;
        logic [5:0] fo, ro;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            do_cfg(2'd0, 5'(pa[k]), 5'(pb[k]), err, lat);
        end
        checks++;
        if (pair_cnt_m !== 4'd5) begin
            errors++;
            $display("FAIL clear_setup: got cnt=%0d want 5", pair_cnt_m);
        end
        n = 0;
        while (!cfg_ready_m && n < 20) begin
            tick();
            n++;
        end
        fw_in_valid = 1'b1; fw_in_char = 5'd0;
        rev_in_valid = 1'b1; rev_in_char = 5'd25;
        cfg_valid = 1'b1; cfg_op = 2'd2; cfg_a = 5'd0; cfg_b = 5'd0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if ({fw_out_valid_m, fw_out_char_m} !== {1'b1, 5'd4} ||
            {rev_out_valid_m, rev_out_char_m} !== {1'b1, 5'd5}) begin
            errors++;
            $display("FAIL clear_first_lookup: got fw=%0b/%0d rev=%0b/%0d want 1/4 1/5",
                     fw_out_valid_m, fw_out_char_m, rev_out_valid_m, rev_out_char_m);
        end
        lat = 1;
        stalls = 0;
        while (!cfg_done_m && lat < 60) begin
            if (!fw_in_ready_m && !rev_in_ready_m) stalls++;
            tick();
            lat++;
        end
        checks++;
        if (stalls !== 26 || lat !== 27 || cfg_err_m !== 3'd0) begin
            errors++;
            $display("FAIL clear_timing: got stalls=%0d lat=%0d err=%0d want 26 27 0",
                     stalls, lat, cfg_err_m);
        end
        checks++;
        if (fw_out_valid_m !== 1'b0 || rev_out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL clear_stall_valid: got fw=%0b rev=%0b want 0 0", fw_out_valid_m, rev_out_valid_m);
        end
        tick();
        fw_in_valid = 1'b0; rev_in_valid = 1'b0;
        checks++;
        if ({fw_out_valid_m, fw_out_char_m} !== {1'b1, 5'd0} ||
            {rev_out_valid_m, rev_out_char_m} !== {1'b1, 5'd25} || pair_cnt_m !== 4'd0) begin
            errors++;
            $display("FAIL clear_after: got fw=%0b/%0d rev=%0b/%0d cnt=%0d want 1/0 1/25 0",
                     fw_out_valid_m, fw_out_char_m, rev_out_valid_m, rev_out_char_m, pair_cnt_m);
        end
        for (int i = 0; i < 26; i++) begin
            look(5'(i), 5'(25 - i), fo, ro);
            checks++;
            if (fo !== {1'b1, 5'(i)} || ro !== {1'b1, 5'(25 - i)}) begin
                errors++;
                $display("FAIL clear_identity_%0d: got fw=%h rev=%h want %0d %0d", i, fo, ro, i, 25 - i);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [2:0] err;
        int lat, n, pulses;
        logic [5:0] fo, ro;
        do_cfg(2'd0, 5'd12, 5'd20, err, lat);
        n = 0;
        while (!cfg_ready_m && n < 20) begin
            tick();
            n++;
        end
        cfg_valid = 1'b1; cfg_op = 2'd2;
        tick();
        cfg_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready_m, cfg_done_m, pair_cnt_m} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL midclear_reset: got rdy=%0b done=%0b cnt=%0d want 1 0 0",
                     cfg_ready_m, cfg_done_m, pair_cnt_m);
        end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (cfg_done_m) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0 || cfg_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL midclear_nodone: got pulses=%0d rdy=%0b want 0 1", pulses, cfg_ready_m);
        end
        look(5'd12, 5'd20, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd12} || ro !== {1'b1, 5'd20}) begin
            errors++;
            $display("FAIL midclear_identity: got fw=%h rev=%h want 2c 34", fo, ro);
        end
    endtask

`ifdef PB_CFG_LOCK_EN
    task automatic test_lock();
        logic [2:0] err;
        int lat;
        logic [5:0] fo, ro;
        cfg_lock = 1'b1;
        do_cfg(2'd0, 5'd2, 5'd5, err, lat);
        checks++;
        if (err !== 3'd7 || lat !== 1 || pair_cnt_m !== 4'd0) begin
            errors++;
            $display("FAIL lock_add: got err=%0d lat=%0d cnt=%0d want 7 1 0", err, lat, pair_cnt_m);
        end
        look(5'd2, 5'd5, fo, ro);
        checks++;
        if (fo !== {1'b1, 5'd2} || ro !== {1'b1, 5'd5}) begin
            errors++;
            $display("FAIL lock_lookup: got fw=%h rev=%h want 22 25", fo, ro);
        end
        do_cfg(2'd2, 5'd0, 5'd0, err, lat);
        checks++;
        if (err !== 3'd7 || lat !== 1) begin
            errors++;
            $display("FAIL lock_clear: got err=%0d lat=%0d want 7 1", err, lat);
        end
        cfg_lock = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [2:0] err;
        int lat;
        for (int i = 0; i < 4; i++) begin
            fw_in_valid = 1'b1; fw_in_char = 5'(i);
            rev_in_valid = 1'b1; rev_in_char = 5'(20 + i);
            tick();
            checks++;
            if ({fw_out_valid_m, fw_out_char_m} !== {1'b1, 5'(i)} ||
                {rev_out_valid_m, rev_out_char_m} !== {1'b1, 5'(20 + i)}) begin
                errors++;
                $display("FAIL b2b_%0d: got fw=%0b/%0d rev=%0b/%0d want 1/%0d 1/%0d",
                         i, fw_out_valid_m, fw_out_char_m, rev_out_valid_m, rev_out_char_m, i, 20 + i);
            end
        end
        fw_in_char = 5'd6;
        rev_in_char = 5'd8;
        do_cfg(2'd0, 5'd6, 5'd8, err, lat);
        checks++;
        if (fw_out_char_m !== 5'd6 || rev_out_char_m !== 5'd8 || err !== 3'd0) begin
            errors++;
            $display("FAIL write_cycle_old: got fw=%0d rev=%0d err=%0d want 6 8 0",
                     fw_out_char_m, rev_out_char_m, err);
        end
        tick();
        fw_in_valid = 1'b0; rev_in_valid = 1'b0;
        checks++;
        if (fw_out_char_m !== 5'd8 || rev_out_char_m !== 5'd6 || fw_out_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL write_next_new: got fw=%0d rev=%0d v=%0b want 8 6 1",
                     fw_out_char_m, rev_out_char_m, fw_out_valid_m);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_errors();
        test_full();
        test_clear();
        test_reset_mid_clear();
`ifdef PB_CFG_LOCK_EN
        test_lock();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
